// File: rtl/hc_gate_tester_if.sv
// Stimulus/response bus between a run controller, hc_gate_tester and the gate under test.
// master: the controller side (issues start, owns the device model); slave: the tester.
interface hc_gate_tester_if #(
    parameter int unsigned ERR_W = 9
);
    logic             start;
    logic [2:0]       gate_sel;
    logic [5:0]       dut_a;
    logic [3:0]       dut_b;
    logic [5:0]       dut_y;
    logic             busy;
    logic             done;
    logic             pass;
    logic             sel_err;
    logic [ERR_W-1:0] err_count;
    logic [7:0]       first_fail_vec;
    logic             first_fail_valid;

    modport master (
        output start, gate_sel, dut_y,
        input  dut_a, dut_b, busy, done, pass, sel_err,
               err_count, first_fail_vec, first_fail_valid
    );

    modport slave (
        input  start, gate_sel, dut_y,
        output dut_a, dut_b, busy, done, pass, sel_err,
               err_count, first_fail_vec, first_fail_valid
    );
endinterface

// File: rtl/hc_gate_tester.sv
// Exhaustive self-checking sequencer for 74HC quad/hex gates (HC00/02/04/08/32/86).
// Walks every input vector, waits SETTLE cycles, samples the device outputs and
// accumulates mismatch count and first failing vector.
module hc_gate_tester #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned ERR_W  = 9
) (
    input logic             clk,
    input logic             rst,
    hc_gate_tester_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRIVE = 3'd1,
        S_WAIT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        G_NAND = 3'd0,
        G_NOR  = 3'd1,
        G_INV  = 3'd2,
        G_AND  = 3'd3,
        G_OR   = 3'd4,
        G_XOR  = 3'd5
    } gate_e;

    // Value loaded into the settle counter on entry to WAIT; WAIT exits when it reaches 0.
    localparam logic [3:0]       SETTLE_LAST = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;

    state_e           state_q,    state_d;
    gate_e            sel_q,      sel_d;
    logic [7:0]       vec_q,      vec_d;
    logic [3:0]       settle_q,   settle_d;
    logic [5:0]       dut_a_q,    dut_a_d;
    logic [3:0]       dut_b_q,    dut_b_d;
    logic [ERR_W-1:0] err_q,      err_d;
    logic [7:0]       ff_vec_q,   ff_vec_d;
    logic             ff_valid_q, ff_valid_d;
    logic             pass_q,     pass_d;
    logic             sel_err_q,  sel_err_d;

    logic [5:0]       exp_y;
    logic [5:0]       cmp_mask;
    logic             mismatch;
    logic             last_vec;
    logic [7:0]       vec_nxt;

    // Expected response of the latched gate to the vector currently driven, and end-of-sweep detect.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can leave it
        // unassigned and infer a latch.
        exp_y    = '0;
        cmp_mask = 6'h0F;
        case (sel_q)
            G_NAND:  exp_y = {2'b00, ~(dut_a_q[3:0] & dut_b_q)};
            G_NOR:   exp_y = {2'b00, ~(dut_a_q[3:0] | dut_b_q)};
            G_AND:   exp_y = {2'b00,  (dut_a_q[3:0] & dut_b_q)};
            G_OR:    exp_y = {2'b00,  (dut_a_q[3:0] | dut_b_q)};
            G_XOR:   exp_y = {2'b00,  (dut_a_q[3:0] ^ dut_b_q)};
            G_INV: begin
                exp_y    = ~dut_a_q;
                cmp_mask = 6'h3F;
            end
            default: exp_y = '0;
        endcase
        mismatch = |((bus.dut_y ^ exp_y) & cmp_mask);
        last_vec = (sel_q == G_INV) ? (vec_q == 8'd63) : (vec_q == 8'd255);
    end

    // Sequencer next state, vector stepping and result bookkeeping.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        vec_d      = vec_q;
        settle_d   = settle_q;
        dut_a_d    = dut_a_q;
        dut_b_d    = dut_b_q;
        err_d      = err_q;
        ff_vec_d   = ff_vec_q;
        ff_valid_d = ff_valid_q;
        pass_d     = pass_q;
        sel_err_d  = sel_err_q;
        vec_nxt    = vec_q + 8'd1;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.gate_sel <= 3'd5) begin
                        sel_d      = gate_e'(bus.gate_sel);
                        vec_d      = '0;
                        err_d      = '0;
                        ff_vec_d   = '0;
                        ff_valid_d = 1'b0;
                        pass_d     = 1'b0;
                        sel_err_d  = 1'b0;
                        dut_a_d    = '0;
                        dut_b_d    = '0;
                        state_d    = S_DRIVE;
                    end else begin
                        sel_err_d  = 1'b1;
                        pass_d     = 1'b0;
                        err_d      = '0;
                        ff_valid_d = 1'b0;
                        state_d    = S_DONE;
                    end
                end
            end
            S_DRIVE: begin
                if (SETTLE == 0) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = SETTLE_LAST;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (settle_q == 4'd0) begin
                    state_d = S_CHECK;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            S_CHECK: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    if (!ff_valid_q) begin
                        ff_vec_d   = vec_q;
                        ff_valid_d = 1'b1;
                    end
                end
                if (last_vec) begin
                    dut_a_d = '0;
                    dut_b_d = '0;
                    // Uses err_d so a mismatch on the final vector is reflected in pass.
                    pass_d  = !sel_err_q && (err_d == '0);
                    state_d = S_DONE;
                end else begin
                    vec_d = vec_nxt;
                    if (sel_q == G_INV) begin
                        dut_a_d = vec_nxt[5:0];
                        dut_b_d = '0;
                    end else begin
                        dut_a_d = {2'b00, vec_nxt[3:0]};
                        dut_b_d = vec_nxt[7:4];
                    end
                    state_d = S_DRIVE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register is computed from pre-edge values,
        // independent of statement order.
        if (rst) begin
            state_q    <= S_IDLE;
            sel_q      <= G_NAND;
            vec_q      <= '0;
            settle_q   <= '0;
            dut_a_q    <= '0;
            dut_b_q    <= '0;
            err_q      <= '0;
            ff_vec_q   <= '0;
            ff_valid_q <= 1'b0;
            pass_q     <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            vec_q      <= vec_d;
            settle_q   <= settle_d;
            dut_a_q    <= dut_a_d;
            dut_b_q    <= dut_b_d;
            err_q      <= err_d;
            ff_vec_q   <= ff_vec_d;
            ff_valid_q <= ff_valid_d;
            pass_q     <= pass_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign bus.dut_a            = dut_a_q;
    assign bus.dut_b            = dut_b_q;
    assign bus.busy             = (state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_CHECK);
    assign bus.done             = (state_q == S_DONE);
    assign bus.pass             = pass_q;
    assign bus.sel_err          = sel_err_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail_vec   = ff_vec_q;
    assign bus.first_fail_valid = ff_valid_q;

endmodule

// File: tb/tb_hc_gate_tester.sv
// Bench for hc_gate_tester: two instances (SETTLE=2/ERR_W=9 and SETTLE=0/ERR_W=5), each
// beside a configurable faulty gate model, checked against a vector-sweep reference.
module tb_hc_gate_tester;

    localparam int LIMIT = 1200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Gate model configuration per instance: emulated gate, outputs tied low, stuck-at
    // masks, one inverted vector, and the value driven on the unused Y[5:4].
    int         m_sel    [2];
    logic       m_tie0   [2];
    logic [5:0] m_s0     [2];
    logic [5:0] m_s1     [2];
    logic       m_bad_en [2];
    logic [7:0] m_bad    [2];
    logic [1:0] m_hi     [2];

    always #5 clk = ~clk;

    hc_gate_tester_if #(.ERR_W(9)) bus0 ();
    hc_gate_tester_if #(.ERR_W(5)) bus1 ();

    hc_gate_tester #(.SETTLE(2), .ERR_W(9)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    hc_gate_tester #(.SETTLE(0), .ERR_W(5)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    function automatic logic [5:0] ideal_y(input int g, input logic [5:0] a, input logic [3:0] b);
        logic [3:0] x;
        x = a[3:0];
        case (g)
            0:       return {2'b00, ~(x & b)};
            1:       return {2'b00, ~(x | b)};
            2:       return ~a;
            3:       return {2'b00, x & b};
            4:       return {2'b00, x | b};
            5:       return {2'b00, x ^ b};
            default: return 6'd0;
        endcase
    endfunction

    function automatic logic [5:0] model_y(input int g, input logic tie0, input logic [5:0] s0,
                                           input logic [5:0] s1, input logic bad_en,
                                           input logic [7:0] bad, input logic [1:0] hi,
                                           input logic [5:0] a, input logic [3:0] b);
        logic [5:0] y;
        logic [7:0] v;
        y = ideal_y(g, a, b);
        if (g != 2) y[5:4] = hi;
        v = (g == 2) ? {2'b00, a} : {b, a[3:0]};
        if (bad_en && v == bad) y = ~y;
        y = (y & ~s0) | s1;
        if (tie0) y = 6'd0;
        return y;
    endfunction

    assign bus0.dut_y = model_y(m_sel[0], m_tie0[0], m_s0[0], m_s1[0], m_bad_en[0], m_bad[0], m_hi[0],
                                bus0.dut_a, bus0.dut_b);
    assign bus1.dut_y = model_y(m_sel[1], m_tie0[1], m_s0[1], m_s1[1], m_bad_en[1], m_bad[1], m_hi[1],
                                bus1.dut_a, bus1.dut_b);

    task automatic set_model(input int d, input int g);
        m_sel[d] = g; m_tie0[d] = 1'b0; m_s0[d] = 6'd0; m_s1[d] = 6'd0;
        m_bad_en[d] = 1'b0; m_bad[d] = 8'd0; m_hi[d] = 2'b10;
    endtask

    task automatic set_start(input int d, input logic s, input logic [2:0] g);
        if (d == 0) begin bus0.start = s; bus0.gate_sel = g; end
        else        begin bus1.start = s; bus1.gate_sel = g; end
    endtask

    task automatic get_res(input int d, output logic [31:0] err, output logic [31:0] ffv,
                           output logic ffvalid, output logic pass, output logic sel_err,
                           output logic busy, output logic done, output logic [5:0] a,
                           output logic [3:0] b);
        if (d == 0) begin
            err = 32'(bus0.err_count); ffv = 32'(bus0.first_fail_vec); ffvalid = bus0.first_fail_valid;
            pass = bus0.pass; sel_err = bus0.sel_err; busy = bus0.busy; done = bus0.done;
            a = bus0.dut_a; b = bus0.dut_b;
        end else begin
            err = 32'(bus1.err_count); ffv = 32'(bus1.first_fail_vec); ffvalid = bus1.first_fail_valid;
            pass = bus1.pass; sel_err = bus1.sel_err; busy = bus1.busy; done = bus1.done;
            a = bus1.dut_a; b = bus1.dut_b;
        end
    endtask

    // Reference: sweep every vector of the selected gate through the device model and
    // tally mismatches on the compared bits.
    task automatic ref_run(input int d, input int sel, input int errw, output int exp_err,
                           output int exp_ffv, output logic exp_ffvalid, output logic exp_pass);
        int         n, errs;
        logic [7:0] v;
        logic [5:0] a, y, mask;
        logic [3:0] b;
        n = (sel == 2) ? 64 : 256;
        mask = (sel == 2) ? 6'h3F : 6'h0F;
        errs = 0; exp_ffv = 0; exp_ffvalid = 1'b0;
        for (int i = 0; i < n; i++) begin
            v = 8'(i);
            if (sel == 2) begin a = v[5:0]; b = 4'd0; end
            else          begin a = {2'b00, v[3:0]}; b = v[7:4]; end
            y = model_y(m_sel[d], m_tie0[d], m_s0[d], m_s1[d], m_bad_en[d], m_bad[d], m_hi[d], a, b);
            if (((y ^ ideal_y(sel, a, b)) & mask) != 6'd0) begin
                if (!exp_ffvalid) begin exp_ffv = i; exp_ffvalid = 1'b1; end
                errs++;
            end
        end
        exp_err  = (errs > (1 << errw) - 1) ? (1 << errw) - 1 : errs;
        exp_pass = (errs == 0);
    endtask

    // Start a run at the current falling edge and follow it to two cycles past done.
    // Cycle k is the k-th cycle after the start cycle. Counts cycles whose busy/dut_a/dut_b
    // disagree with the vector that should be on the bus, and done pulses seen.
    // Optionally pulses start again with inj_sel at cycle inj_k.
    task automatic do_run(input int d, input logic [2:0] sel, input int inj_k, input logic [2:0] inj_sel,
                          output int done_at, output int bad_cycles, output int dones);
        int          s, v;
        logic        legal, exp_busy;
        logic [7:0]  vv;
        logic [5:0]  ea, a;
        logic [3:0]  eb, b;
        logic [31:0] err, ffv;
        logic        ffvalid, pass, sel_err, busy, done;
        s = (d == 0) ? 2 : 0;
        legal = (sel <= 3'd5);
        done_at = -1; bad_cycles = 0; dones = 0;
        set_start(d, 1'b1, sel);
        for (int k = 1; k <= LIMIT; k++) begin
            @(negedge clk);
            if (k == 1) set_start(d, 1'b0, 3'($urandom_range(0, 7)));
            if (k == inj_k) set_start(d, 1'b1, inj_sel);
            else if (inj_k != 0 && k == inj_k + 1) set_start(d, 1'b0, inj_sel);
            get_res(d, err, ffv, ffvalid, pass, sel_err, busy, done, a, b);
            if (done === 1'b1) begin
                dones++;
                if (done_at < 0) done_at = k;
            end
            ea = 6'd0; eb = 4'd0; exp_busy = 1'b0;
            if (legal && done_at < 0) begin
                v = (k - 1) / (s + 2);
                vv = 8'(v);
                exp_busy = 1'b1;
                if (sel == 3'd2) ea = vv[5:0];
                else begin ea = {2'b00, vv[3:0]}; eb = vv[7:4]; end
            end
            if (busy !== exp_busy || a !== ea || b !== eb) bad_cycles++;
            if (done_at > 0 && k >= done_at + 2) break;
        end
    endtask

    task automatic test_reset();
        logic [31:0] err, ffv;
        logic        ffvalid, pass, sel_err, busy, done;
        logic [5:0]  a;
        logic [3:0]  b;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            get_res(d, err, ffv, ffvalid, pass, sel_err, busy, done, a, b);
            n_checks++; if ({busy, done, pass, sel_err, ffvalid} !== 5'b0) $display("FAIL reset_flags dut%0d: got %b expected 00000", d, {busy, done, pass, sel_err, ffvalid}); else n_pass++;
            n_checks++; if (err !== 32'd0 || ffv !== 32'd0) $display("FAIL reset_counts dut%0d: got err=%0d ffv=%0d expected 0/0", d, err, ffv); else n_pass++;
            n_checks++; if (a !== 6'd0 || b !== 4'd0) $display("FAIL reset_dut_ab dut%0d: got a=%0h b=%0h expected 0/0", d, a, b); else n_pass++;
        end
        rst = 1'b0;
        @(negedge clk);
        get_res(0, err, ffv, ffvalid, pass, sel_err, busy, done, a, b);
        n_checks++; if ({busy, done} !== 2'b00) $display("FAIL idle_after_reset: got busy/done=%b expected 00", {busy, done}); else n_pass++;
    endtask

    task automatic test_good_nand();
        int done_at, bad, dones;
        logic [31:0] err, ffv;
        logic ffvalid, pass, sel_err, busy, done;
        logic [5:0] a;
        logic [3:0] b;
        set_model(0, 0);
        do_run(0, 3'd0, 0, 3'd0, done_at, bad, dones);
        get_res(0, err, ffv, ffvalid, pass, sel_err, busy, done, a, b);
        n_checks++; if (done_at !== 1025) $display("FAIL nand_done_cycle: got %0d expected 1025", done_at); else n_pass++;
        n_checks++; if (bad !== 0 || dones !== 1) $display("FAIL nand_profile: got bad_cycles=%0d dones=%0d expected 0/1", bad, dones); else n_pass++;
        n_checks++; if (pass !== 1'b1 || err !== 32'd0 || ffvalid !== 1'b0) $display("FAIL nand_result: got pass=%b err=%0d ffvalid=%b expected 1/0/0", pass, err, ffvalid); else n_pass++;
    endtask

    task automatic test_and_stuck();
        int done_at, bad, dones;
        logic [31:0] err, ffv;
        logic ffvalid, pass, sel_err, busy, done;
        logic [5:0] a;
        logic [3:0] b;
        set_model(0, 3);
        m_s0[0] = 6'h01;
        do_run(0, 3'd3, 0, 3'd0, done_at, bad, dones);
        get_res(0, err, ffv, ffvalid, pass, sel_err, busy, done, a, b);
        n_checks++; if (done_at !== 1025 || bad !== 0) $display("FAIL and_stuck_timing: got done=%0d bad_cycles=%0d expected 1025/0", done_at, bad); else n_pass++;
        n_checks++; if (err !== 32'd64) $display("FAIL and_stuck_err_count: got %0d expected 64", err); else n_pass++;
        n_checks++; if (ffv !== 32'h11 || ffvalid !== 1'b1) $display("FAIL and_stuck_first_fail: got vec=%0h valid=%b expected 11/1", ffv, ffvalid); else n_pass++;
        n_checks++; if (pass !== 1'b0) $display("FAIL and_stuck_pass: got %b expected 0", pass); else n_pass++;
    endtask

    task automatic test_inv_sat();
        int done_at, bad, dones;
        logic [31:0] err, ffv;
        logic ffvalid, pass, sel_err, busy, done;
        logic [5:0] a;
        logic [3:0] b;
        set_model(1, 2);
        m_tie0[1] = 1'b1;
        do_run(1, 3'd2, 0, 3'd0, done_at, bad, dones);
        get_res(1, err, ffv, ffvalid, pass, sel_err, busy, done, a, b);
        n_checks++; if (done_at !== 129 || bad !== 0) $display("FAIL inv_sat_timing: got done=%0d bad_cycles=%0d expected 129/0", done_at, bad); else n_pass++;
        n_checks++; if (err !== 32'd31) $display("FAIL inv_sat_err_count: got %0d expected 31", err); else n_pass++;
        n_checks++; if (ffv !== 32'h00 || ffvalid !== 1'b1 || pass !== 1'b0) $display("FAIL inv_sat_result: got vec=%0h valid=%b pass=%b expected 0/1/0", ffv, ffvalid, pass); else n_pass++;
    endtask

    task automatic test_illegal();
        int done_at, bad, dones;
        logic [31:0] err, ffv;
        logic ffvalid, pass, sel_err, busy, done;
        logic [5:0] a;
        logic [3:0] b;
        set_model(0, 5);
        do_run(0, 3'd6, 0, 3'd0, done_at, bad, dones);
        get_res(0, err, ffv, ffvalid, pass, sel_err, busy, done, a, b);
        n_checks++; if (done_at !== 1 || dones !== 1) $display("FAIL illegal6_done: got done=%0d pulses=%0d expected 1/1", done_at, dones); else n_pass++;
        n_checks++; if (bad !== 0) $display("FAIL illegal6_busy: got %0d cycles with busy or bus activity expected 0", bad); else n_pass++;
        n_checks++; if (sel_err !== 1'b1 || pass !== 1'b0 || err !== 32'd0 || ffvalid !== 1'b0) $display("FAIL illegal6_result: got sel_err=%b pass=%b err=%0d ffvalid=%b expected 1/0/0/0", sel_err, pass, err, ffvalid); else n_pass++;
        do_run(0, 3'd5, 0, 3'd0, done_at, bad, dones);
        get_res(0, err, ffv, ffvalid, pass, sel_err, busy, done, a, b);
        n_checks++; if (done_at !== 1025 || pass !== 1'b1 || sel_err !== 1'b0) $display("FAIL xor_after_illegal: got done=%0d pass=%b sel_err=%b expected 1025/1/0", done_at, pass, sel_err); else n_pass++;
        do_run(1, 3'd7, 0, 3'd0, done_at, bad, dones);
        get_res(1, err, ffv, ffvalid, pass, sel_err, busy, done, a, b);
        n_checks++; if (done_at !== 1 || bad !== 0 || sel_err !== 1'b1 || pass !== 1'b0) $display("FAIL illegal7: got done=%0d bad=%0d sel_err=%b pass=%b expected 1/0/1/0", done_at, bad, sel_err, pass); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        int done_at, bad, dones;
        logic [31:0] err, ffv;
        logic ffvalid, pass, sel_err, busy, done;
        logic [5:0] a;
        logic [3:0] b;
        logic saw_done, saw_busy;
        saw_done = 1'b0; saw_busy = 1'b0;
        set_model(0, 4);
        set_start(0, 1'b1, 3'd4);
        for (int k = 1; k <= 1400; k++) begin
            @(negedge clk);
            if (k == 1) set_start(0, 1'b0, 3'd4);
            get_res(0, err, ffv, ffvalid, pass, sel_err, busy, done, a, b);
            if (k == 300) begin
                n_checks++; if (busy !== 1'b1) $display("FAIL midrun_busy_before_reset: got %b expected 1", busy); else n_pass++;
                rst = 1'b1;
            end
            if (k == 301) begin
                rst = 1'b0;
                n_checks++; if ({busy, done, pass, sel_err, ffvalid} !== 5'b0 || err !== 32'd0 || ffv !== 32'd0 || a !== 6'd0 || b !== 4'd0)
                    $display("FAIL midrun_reset_values: got flags=%b err=%0d ffv=%0d a=%0h b=%0h expected all 0", {busy, done, pass, sel_err, ffvalid}, err, ffv, a, b);
                else n_pass++;
            end
            if (k > 300) begin
                if (done !== 1'b0) saw_done = 1'b1;
                if (busy !== 1'b0) saw_busy = 1'b1;
            end
        end
        n_checks++; if (saw_done !== 1'b0 || saw_busy !== 1'b0) $display("FAIL midrun_aborted: got done_seen=%b busy_seen=%b expected 0/0", saw_done, saw_busy); else n_pass++;
        do_run(0, 3'd4, 0, 3'd0, done_at, bad, dones);
        get_res(0, err, ffv, ffvalid, pass, sel_err, busy, done, a, b);
        n_checks++; if (done_at !== 1025 || bad !== 0 || pass !== 1'b1) $display("FAIL midrun_rerun: got done=%0d bad=%0d pass=%b expected 1025/0/1", done_at, bad, pass); else n_pass++;
    endtask

    task automatic test_start_while_busy();
        int done_at, bad, dones;
        logic [31:0] err, ffv;
        logic ffvalid, pass, sel_err, busy, done;
        logic [5:0] a;
        logic [3:0] b;
        set_model(0, 5);
        do_run(0, 3'd5, 100, 3'd1, done_at, bad, dones);
        get_res(0, err, ffv, ffvalid, pass, sel_err, busy, done, a, b);
        n_checks++; if (done_at !== 1025 || dones !== 1) $display("FAIL busy_start_done: got done=%0d pulses=%0d expected 1025/1", done_at, dones); else n_pass++;
        n_checks++; if (bad !== 0 || pass !== 1'b1 || err !== 32'd0) $display("FAIL busy_start_result: got bad=%0d pass=%b err=%0d expected 0/1/0", bad, pass, err); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int done_at, bad, dones, k_done;
        logic [31:0] err, ffv;
        logic ffvalid, pass, sel_err, busy, done;
        logic [5:0] a;
        logic [3:0] b;
        set_model(1, 2);
        k_done = -1;
        set_start(1, 1'b1, 3'd2);
        for (int k = 1; k <= LIMIT; k++) begin
            @(negedge clk);
            if (k == 1) set_start(1, 1'b0, 3'd2);
            get_res(1, err, ffv, ffvalid, pass, sel_err, busy, done, a, b);
            if (done === 1'b1) begin k_done = k; break; end
        end
        n_checks++; if (k_done !== 129 || pass !== 1'b1) $display("FAIL b2b_inv: got done=%0d pass=%b expected 129/1", k_done, pass); else n_pass++;
        set_model(1, 3);
        set_start(1, 1'b1, 3'd3);
        @(negedge clk);
        get_res(1, err, ffv, ffvalid, pass, sel_err, busy, done, a, b);
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL b2b_start_in_done: got busy=%b done=%b expected 0/0", busy, done); else n_pass++;
        do_run(1, 3'd3, 0, 3'd0, done_at, bad, dones);
        get_res(1, err, ffv, ffvalid, pass, sel_err, busy, done, a, b);
        n_checks++; if (done_at !== 513 || bad !== 0 || dones !== 1 || pass !== 1'b1) $display("FAIL b2b_and: got done=%0d bad=%0d pulses=%0d pass=%b expected 513/0/1/1", done_at, bad, dones, pass); else n_pass++;
    endtask

    task automatic test_random();
        int d, sel, g, s, n, errw, exp_done, exp_err, exp_ffv, done_at, bad, dones;
        logic exp_ffvalid, exp_pass, legal;
        logic [31:0] err, ffv;
        logic ffvalid, pass, sel_err, busy, done;
        logic [5:0] a;
        logic [3:0] b;
        for (int it = 0; it < 14; it++) begin
            d = $urandom_range(0, 1);
            sel = ($urandom_range(0, 7) == 7) ? $urandom_range(6, 7) : $urandom_range(0, 5);
            legal = (sel <= 5);
            g = (!legal || $urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : sel;
            set_model(d, g);
            m_tie0[d]   = ($urandom_range(0, 9) == 0);
            m_s0[d]     = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
            m_s1[d]     = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            m_bad_en[d] = 1'($urandom_range(0, 1));
            m_bad[d]    = 8'($urandom);
            m_hi[d]     = 2'($urandom);
            s    = (d == 0) ? 2 : 0;
            errw = (d == 0) ? 9 : 5;
            n    = (sel == 2) ? 64 : 256;
            if (legal) begin
                ref_run(d, sel, errw, exp_err, exp_ffv, exp_ffvalid, exp_pass);
                exp_done = n * (s + 2) + 1;
            end else begin
                exp_err = 0; exp_ffv = 0; exp_ffvalid = 1'b0; exp_pass = 1'b0; exp_done = 1;
            end
            do_run(d, 3'(sel), 0, 3'd0, done_at, bad, dones);
            get_res(d, err, ffv, ffvalid, pass, sel_err, busy, done, a, b);
            n_checks++; if (done_at !== exp_done || bad !== 0 || dones !== 1) $display("FAIL rnd%0d_timing dut%0d sel%0d: got done=%0d bad=%0d pulses=%0d expected %0d/0/1", it, d, sel, done_at, bad, dones, exp_done); else n_pass++;
            n_checks++; if (err !== 32'(exp_err)) $display("FAIL rnd%0d_err_count dut%0d sel%0d gate%0d: got %0d expected %0d", it, d, sel, g, err, exp_err); else n_pass++;
            n_checks++; if (ffvalid !== exp_ffvalid || pass !== exp_pass || sel_err !== !legal) $display("FAIL rnd%0d_flags: got ffvalid=%b pass=%b sel_err=%b expected %b/%b/%b", it, ffvalid, pass, sel_err, exp_ffvalid, exp_pass, !legal); else n_pass++;
            if (legal) begin
                n_checks++; if (ffv !== 32'(exp_ffv)) $display("FAIL rnd%0d_first_fail_vec: got %0h expected %0h", it, ffv, exp_ffv); else n_pass++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        set_start(0, 1'b0, 3'd0);
        set_start(1, 1'b0, 3'd0);
        set_model(0, 0);
        set_model(1, 0);
        test_reset();
        test_good_nand();
        test_and_stuck();
        test_inv_sat();
        test_illegal();
        test_reset_midrun();
        test_start_while_busy();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
